// File: rtl/hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use, multi-cycle multiply,
// data-memory wait states and taken-branch flush. Optional counters: `define HAZARD_PERF_EN.
module hazard_ctrl #(
   parameter int REG_ADDR_W  = 5,
   parameter int MUL_LATENCY = 3,
   parameter int CNT_W       = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   input  logic                  ex_is_mul,
   input  logic                  branch_taken_ex,
   input  logic                  mem_req,
   input  logic                  dmem_ready,
   output logic                  pc_stall,
   output logic                  if_id_stall,
   output logic                  id_ex_stall,
   output logic                  ex_mem_stall,
   output logic                  id_ex_bubble,
   output logic                  ex_mem_bubble,
   output logic                  mem_wb_bubble,
   output logic                  if_id_flush,
   output logic                  busy
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]           stall_cycles,
   output logic [31:0]           flush_count
`endif
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MUL_WAIT = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mul_ack_q, mul_ack_d;

   logic mem_hold;
   logic load_use;

   assign mem_hold = mem_req & ~dmem_ready;
   assign load_use = ex_mem_read && (ex_rd != '0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= RUN;
         cnt_q     <= '0;
         mul_ack_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mul_ack_q <= mul_ack_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      mul_ack_d     = mul_ack_q;
      pc_stall      = 1'b0;
      if_id_stall   = 1'b0;
      id_ex_stall   = 1'b0;
      ex_mem_stall  = 1'b0;
      id_ex_bubble  = 1'b0;
      ex_mem_bubble = 1'b0;
      mem_wb_bubble = 1'b0;
      if_id_flush   = 1'b0;
      busy          = 1'b0;

      case (state_q)
         RUN: begin
            if (mem_hold) begin
               pc_stall      = 1'b1;
               if_id_stall   = 1'b1;
               id_ex_stall   = 1'b1;
               ex_mem_stall  = 1'b1;
               mem_wb_bubble = 1'b1;
               state_d       = MEM_WAIT;
            end else if (ex_is_mul && !mul_ack_q) begin
               pc_stall      = 1'b1;
               if_id_stall   = 1'b1;
               id_ex_stall   = 1'b1;
               ex_mem_bubble = 1'b1;
               cnt_d         = CNT_W'(MUL_LATENCY - 2);
               state_d       = MUL_WAIT;
            end else if (branch_taken_ex) begin
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
            end else if (load_use) begin
               pc_stall     = 1'b1;
               if_id_stall  = 1'b1;
               id_ex_bubble = 1'b1;
            end
            // mul_ack only guards the multiply still sitting in EX; once EX advances it is stale
            if (!id_ex_stall) begin
               mul_ack_d = 1'b0;
            end
         end

         MUL_WAIT: begin
            busy = 1'b1;
            if ((cnt_q == '0) && !mem_hold) begin
               state_d   = RUN;
               mul_ack_d = 1'b1;
            end else begin
               pc_stall    = 1'b1;
               if_id_stall = 1'b1;
               id_ex_stall = 1'b1;
               if (mem_hold) begin
                  ex_mem_stall  = 1'b1;
                  mem_wb_bubble = 1'b1;
               end else begin
                  ex_mem_bubble = 1'b1;
                  cnt_d         = cnt_q - CNT_W'(1);
               end
            end
         end

         MEM_WAIT: begin
            busy = 1'b1;
            if (mem_hold) begin
               pc_stall      = 1'b1;
               if_id_stall   = 1'b1;
               id_ex_stall   = 1'b1;
               ex_mem_stall  = 1'b1;
               mem_wb_bubble = 1'b1;
            end else begin
               state_d = RUN;
            end
         end

         default: begin
            state_d = RUN;
         end
      endcase

      // Outputs are forced quiet for the whole reset window, regardless of state
      if (reset) begin
         pc_stall      = 1'b0;
         if_id_stall   = 1'b0;
         id_ex_stall   = 1'b0;
         ex_mem_stall  = 1'b0;
         id_ex_bubble  = 1'b0;
         ex_mem_bubble = 1'b0;
         mem_wb_bubble = 1'b0;
         if_id_flush   = 1'b0;
         busy          = 1'b0;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cycles_q, flush_count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         if (pc_stall) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
         end
         if (if_id_flush) begin
            flush_count_q <= flush_count_q + 32'd1;
         end
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`endif

endmodule
